pll_speed_sel: RTL and testbench



---
 rtl/pll_speed_sel_pkg.sv | 26 ++
 rtl/pll_speed_sel_sync.sv | 46 ++++
 rtl/pll_speed_sel.sv | 183 ++++++++++++++++++
 tb/tb_pll_speed_sel.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_speed_sel_pkg.sv
// Shared types and constants for the PLL speed selector: FSM state encoding,
// reconfig-controller register map and sequencing constants.
package pll_speed_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_MODE,
    GAP1,
    WR_FRAC,
    GAP2,
    WR_START,
    WAIT_LOCK,
    DONE
  } state_t;

  localparam logic [5:0] REG_MODE  = 6'd0;
  localparam logic [5:0] REG_FRAC  = 6'd7;
  localparam logic [5:0] REG_START = 6'd2;

  // Last gap count value: each GAP state lasts three cycles.
  localparam logic [1:0] GAP_LAST  = 2'd2;

  // Last lock count value: pll_locked must hold for eight cycles.
  localparam logic [2:0] LOCK_LAST = 3'd7;

endpackage

// File: rtl/pll_speed_sel_sync.sv
// Two-flop synchroniser followed by a settle counter; stable_o rises once the
// synchronised value has held for SETTLE consecutive cycles.
module sync_stable #(
  parameter int SETTLE = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic value_o,
  output logic stable_o
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE);

  logic          meta_q;
  logic          sync_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A value about to land in sync_q counts as its first held cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (meta_q != sync_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      cnt_q  <= cnt_d;
    end
  end

  assign value_o  = sync_q;
  assign stable_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pll_speed_sel.sv
// PLL speed selector: reprograms the fractional-M word through the reconfig
// controller when the settled request changes. Optional macro: PLL_SPEED_LOCK_WAIT_EN.
module pll_speed_sel
  import pll_speed_pkg::*;
#(
  parameter logic [31:0] FRAC_NATIVE = 32'd3639383488,
  parameter logic [31:0] FRAC_UNDER  = 32'd3262113561,
  parameter int          SETTLE      = 4,
  parameter logic [15:0] LOCK_TMO    = 16'hFFFF
) (
  input  logic        clk_50m,
  input  logic        reset,
  input  logic        underclock,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        busy,
  output logic        applied,
  output logic        done,
  output logic        lock_err
);

  logic        req_value;
  logic        req_stable;
  logic        start_req;
  logic        wr_phase;

  state_t      state_q;
  logic        req_q;
  logic        applied_q;
  logic        applied_valid_q;
  logic        busy_q;
  logic        done_q;
  logic [5:0]  addr_q;
  logic [31:0] data_q;
  logic [1:0]  gap_cnt_q;

  sync_stable #(
    .SETTLE (SETTLE)
  ) u_req_sync (
    .clk_i    (clk_50m),
    .rst_n_i  (reset),
    .async_i  (underclock),
    .value_o  (req_value),
    .stable_o (req_stable)
  );

`ifdef PLL_SPEED_LOCK_WAIT_EN
  logic        locked_meta_q;
  logic        locked_sync_q;
  logic [2:0]  lock_cnt_q;
  logic [15:0] tmo_cnt_q;
  logic        lock_err_q;

  always_ff @(posedge clk_50m) begin
    if (!reset) begin
      locked_meta_q <= 1'b0;
      locked_sync_q <= 1'b0;
    end else begin
      locked_meta_q <= pll_locked;
      locked_sync_q <= locked_meta_q;
    end
  end

  assign lock_err = lock_err_q;
`else
  logic        unused_pll_locked;
  logic [15:0] unused_lock_tmo;

  assign unused_pll_locked = pll_locked;
  assign unused_lock_tmo   = LOCK_TMO;
  assign lock_err          = 1'b0;
`endif

  assign start_req = req_stable && (!applied_valid_q || (req_value != applied_q));
  assign wr_phase  = (state_q == WR_MODE) || (state_q == WR_FRAC) || (state_q == WR_START);

  // The strobe is qualified by waitrequest in the same cycle, so a busy
  // controller never sees a write and the FSM simply holds.
  assign mgmt_write     = wr_phase && !mgmt_waitrequest;
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = data_q;
  assign busy           = busy_q;
  assign applied        = applied_q;
  assign done           = done_q;

  always_ff @(posedge clk_50m) begin
    if (!reset) begin
      state_q         <= IDLE;
      req_q           <= 1'b0;
      applied_q       <= 1'b0;
      applied_valid_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      addr_q          <= '0;
      data_q          <= '0;
      gap_cnt_q       <= '0;
`ifdef PLL_SPEED_LOCK_WAIT_EN
      lock_cnt_q      <= '0;
      tmo_cnt_q       <= '0;
      lock_err_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (!mgmt_waitrequest) begin
        case (state_q)
          IDLE: begin
            if (start_req) begin
              state_q <= WR_MODE;
              req_q   <= req_value;
              busy_q  <= 1'b1;
              addr_q  <= REG_MODE;
              data_q  <= '0;
            end
          end
          WR_MODE: begin
            state_q   <= GAP1;
            gap_cnt_q <= '0;
          end
          GAP1: begin
            if (gap_cnt_q == GAP_LAST) begin
              state_q <= WR_FRAC;
              addr_q  <= REG_FRAC;
              data_q  <= req_q ? FRAC_UNDER : FRAC_NATIVE;
            end else begin
              gap_cnt_q <= gap_cnt_q + 2'd1;
            end
          end
          WR_FRAC: begin
            state_q   <= GAP2;
            gap_cnt_q <= '0;
          end
          GAP2: begin
            if (gap_cnt_q == GAP_LAST) begin
              state_q <= WR_START;
              addr_q  <= REG_START;
              data_q  <= '0;
            end else begin
              gap_cnt_q <= gap_cnt_q + 2'd1;
            end
          end
          WR_START: begin
`ifdef PLL_SPEED_LOCK_WAIT_EN
            state_q    <= WAIT_LOCK;
            lock_cnt_q <= '0;
            tmo_cnt_q  <= '0;
`else
            state_q    <= DONE;
`endif
          end
`ifdef PLL_SPEED_LOCK_WAIT_EN
          WAIT_LOCK: begin
            // A completed lock wins over a timeout landing in the same cycle.
            if (locked_sync_q && (lock_cnt_q == LOCK_LAST)) begin
              state_q <= DONE;
            end else if (tmo_cnt_q == (LOCK_TMO - 16'd1)) begin
              lock_err_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              tmo_cnt_q  <= tmo_cnt_q + 16'd1;
              lock_cnt_q <= locked_sync_q ? (lock_cnt_q + 3'd1) : 3'd0;
            end
          end
`endif
          DONE: begin
            state_q         <= IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b1;
            applied_q       <= req_q;
            applied_valid_q <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_speed_sel.sv
// Directed self-checking bench for pll_speed_sel: reset state, programming
// sequences, settle filtering, waitrequest stalls, mid-sequence reset, lock wait.
`timescale 1ns/1ps
module tb_pll_speed_sel;

  localparam logic [31:0] NATIVE = 32'd3639383488;
  localparam logic [31:0] UNDER  = 32'd3262113561;

  logic        clk_50m          = 1'b0;
  logic        reset            = 1'b0;
  logic        underclock       = 1'b0;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked       = 1'b0;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        busy;
  logic        applied;
  logic        done;
  logic        lock_err;

  int checks = 0;
  int errors = 0;

  logic [5:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int   wide_wr     = 0;
  int   wr_in_wait  = 0;
  int   wide_done   = 0;
  int   busy_cycles = 0;
  logic prev_wr     = 1'b0;
  logic prev_done   = 1'b0;

  always #10 clk_50m = ~clk_50m;

  pll_speed_sel #(
    .SETTLE   (4),
    .LOCK_TMO (16'd40)
  ) dut (
    .clk_50m          (clk_50m),
    .reset            (reset),
    .underclock       (underclock),
    .mgmt_waitrequest (mgmt_waitrequest),
    .pll_locked       (pll_locked),
    .mgmt_write       (mgmt_write),
    .mgmt_address     (mgmt_address),
    .mgmt_writedata   (mgmt_writedata),
    .busy             (busy),
    .applied          (applied),
    .done             (done),
    .lock_err         (lock_err)
  );

  // Bus monitor, sampled mid-cycle.
  always @(negedge clk_50m) begin
    if (mgmt_write === 1'b1) begin
      wr_addr.push_back(mgmt_address);
      wr_data.push_back(mgmt_writedata);
      if (mgmt_waitrequest) wr_in_wait++;
      if (prev_wr) wide_wr++;
      $display("%0t WRITE addr=%0d data=%0d", $time, mgmt_address, mgmt_writedata);
    end
    if (done === 1'b1 && prev_done) wide_done++;
    if (busy === 1'b1) busy_cycles++;
    prev_wr   = (mgmt_write === 1'b1);
    prev_done = (done === 1'b1);
  end

  initial begin
    #200us;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_50m);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done !== 1'b1 && k < 300) begin
      step();
      k++;
    end
    chk(tag, 64'(done === 1'b1), 64'd1);
  endtask

  task automatic wait_write(input string tag, input logic [5:0] addr);
    int k = 0;
    while (!(mgmt_write === 1'b1 && mgmt_address === addr) && k < 300) begin
      step();
      k++;
    end
    chk(tag, 64'(mgmt_write === 1'b1 && mgmt_address === addr), 64'd1);
  endtask

  initial begin
    int n0;
    int n1;
    int b0;
    int k;
`ifdef PLL_SPEED_LOCK_WAIT_EN
    pll_locked = 1'b1;
`endif
    // Reset state
    step(3);
    chk("rst_write", 64'(mgmt_write), 64'd0);
    chk("rst_addr", 64'(mgmt_address), 64'd0);
    chk("rst_data", 64'(mgmt_writedata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_applied", 64'(applied), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_lock_err", 64'(lock_err), 64'd0);
    reset = 1'b1;

    // First sequence after reset programs native speed
    wait_done("a_done");
    chk("a_nwr", 64'(wr_addr.size()), 64'd3);
    chk("a_addr0", 64'(wr_addr[0]), 64'd0);
    chk("a_data0", 64'(wr_data[0]), 64'd0);
    chk("a_addr1", 64'(wr_addr[1]), 64'd7);
    chk("a_data1", 64'(wr_data[1]), 64'(NATIVE));
    chk("a_addr2", 64'(wr_addr[2]), 64'd2);
    chk("a_data2", 64'(wr_data[2]), 64'd0);
    chk("a_applied", 64'(applied), 64'd0);
    chk("a_busy", 64'(busy), 64'd0);
    step();
    chk("a_done_pulse", 64'(done), 64'd0);

    // Glitch shorter than the settle window is ignored
    n0 = wr_addr.size();
    b0 = busy_cycles;
    underclock = 1'b1;
    step(3);
    underclock = 1'b0;
    step(20);
    chk("g_nwr", 64'(wr_addr.size()), 64'(n0));
    chk("g_busy", 64'(busy_cycles), 64'(b0));

    // Underclock request: first strobe exactly SETTLE+2 edges later
    n0 = wr_addr.size();
    underclock = 1'b1;
    step(5);
    chk("u_write_early", 64'(mgmt_write), 64'd0);
    chk("u_busy_early", 64'(busy), 64'd0);
    step();
    chk("u_write_lat", 64'(mgmt_write), 64'd1);
    chk("u_addr_lat", 64'(mgmt_address), 64'd0);
    chk("u_busy", 64'(busy), 64'd1);
    wait_done("u_done");
    chk("u_nwr", 64'(wr_addr.size()), 64'(n0 + 3));
    chk("u_addr1", 64'(wr_addr[n0 + 1]), 64'd7);
    chk("u_data1", 64'(wr_data[n0 + 1]), 64'(UNDER));
    chk("u_applied", 64'(applied), 64'd1);

    // Waitrequest stall in GAP1
    n0 = wr_addr.size();
    underclock = 1'b0;
    wait_write("s_wr_mode", 6'd0);
    step();
    mgmt_waitrequest = 1'b1;
    step(10);
    chk("s_nwr_stall", 64'(wr_addr.size()), 64'(n0 + 1));
    chk("s_busy_stall", 64'(busy), 64'd1);
    mgmt_waitrequest = 1'b0;
    k = 0;
    while (mgmt_write !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk("s_resume_cycles", 64'(k), 64'd3);
    chk("s_addr", 64'(mgmt_address), 64'd7);
    chk("s_data", 64'(mgmt_writedata), 64'(NATIVE));
    step();
    chk("s_strobe_width", 64'(mgmt_write), 64'd0);
    chk("s_addr_hold", 64'(mgmt_address), 64'd7);
    wait_done("s_done");
    chk("s_applied", 64'(applied), 64'd0);

    // Request flips during WR_FRAC: current sequence finishes, then another follows
    n0 = wr_addr.size();
    underclock = 1'b1;
    wait_write("t_wr_frac", 6'd7);
    underclock = 1'b0;
    wait_done("t_done1");
    chk("t_data1", 64'(wr_data[n0 + 1]), 64'(UNDER));
    chk("t_applied1", 64'(applied), 64'd1);
    step();
    wait_done("t_done2");
    chk("t_nwr", 64'(wr_addr.size()), 64'(n0 + 6));
    chk("t_data2", 64'(wr_data[n0 + 4]), 64'(NATIVE));
    chk("t_applied2", 64'(applied), 64'd0);

    // Reset mid-sequence abandons it; a full reprogram follows release
    n0 = wr_addr.size();
    underclock = 1'b1;
    wait_write("r_wr_mode", 6'd0);
    step(2);
    reset = 1'b0;
    step(2);
    chk("r_busy", 64'(busy), 64'd0);
    chk("r_write", 64'(mgmt_write), 64'd0);
    chk("r_applied", 64'(applied), 64'd0);
    reset = 1'b1;
    n1 = wr_addr.size();
    chk("r_partial", 64'(n1), 64'(n0 + 1));
    wait_done("r_done");
    chk("r_nwr", 64'(wr_addr.size()), 64'(n1 + 3));
    chk("r_data1", 64'(wr_data[n1 + 1]), 64'(UNDER));
    chk("r_applied2", 64'(applied), 64'd1);

`ifdef PLL_SPEED_LOCK_WAIT_EN
    // Lock never arrives: timeout flags lock_err, sequence still completes
    pll_locked = 1'b0;
    underclock = 1'b0;
    wait_done("l_done");
    chk("l_lock_err", 64'(lock_err), 64'd1);
    chk("l_applied", 64'(applied), 64'd0);
    pll_locked = 1'b1;
    step(5);
    chk("l_sticky", 64'(lock_err), 64'd1);
    reset = 1'b0;
    step(2);
    chk("l_rst_clear", 64'(lock_err), 64'd0);
    reset = 1'b1;
    step(2);
`else
    chk("l_tied", 64'(lock_err), 64'd0);
`endif

    chk("m_wide_write", 64'(wide_wr), 64'd0);
    chk("m_write_in_wait", 64'(wr_in_wait), 64'd0);
    chk("m_wide_done", 64'(wide_done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
